// File: rtl/pulpemu_rst_seq.sv
// pulpemu_rst_seq: synchronises, debounces and masks reset requests, then sequences staggered domain reset release.
// Latency: src_i active -> rst_n_o low after 3 edges (plus DEBOUNCE_CYCLES when debounce is built in); sw_rst_req_i -> 1 edge.
// Backpressure: none; requests are sampled every cycle and all outputs are registered.
// Build option: define PULPEMU_RST_DEBOUNCE_EN to include the per-source debounce counters.
module pulpemu_rst_seq #(
  parameter int unsigned        NUM_SRC         = 2,
  parameter int unsigned        NUM_OUT         = 3,
  parameter logic [NUM_SRC-1:0] SRC_ACTIVE_LOW  = '1,
  parameter int unsigned        DEBOUNCE_CYCLES = 4,
  parameter int unsigned        STRETCH_CYCLES  = 10,
  parameter int unsigned        STAGGER_CYCLES  = 3
) (
  input  logic               ref_clk,
  input  logic               pad_reset,
  input  logic [NUM_SRC-1:0] src_i,
  input  logic [NUM_SRC-1:0] src_mask_i,
  input  logic               sw_rst_req_i,
  input  logic               cause_clr_i,
  output logic [NUM_OUT-1:0] rst_n_o,
  output logic               rst_done_o,
  output logic [NUM_SRC:0]   rst_cause_o
);

  // Terminal values for the stretch and stagger counters (count 0..N-1).
  localparam logic [15:0]        STRETCH_LAST = 16'(STRETCH_CYCLES - 1);
  localparam logic [7:0]         STAGGER_LAST = 8'(STAGGER_CYCLES - 1);
  localparam logic [NUM_OUT-1:0] ALL_REL      = '1;
  localparam logic [NUM_OUT-1:0] FIRST_REL    = NUM_OUT'(1);

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // Request front end
  // ---------------------------------------------------------------------------
  logic [NUM_SRC-1:0] sync1_q;
  logic [NUM_SRC-1:0] sync2_q;
  logic [NUM_SRC-1:0] src_act;
  logic [NUM_SRC-1:0] qual_src;
  logic [NUM_SRC:0]   qual_vec;
  logic               any_req;

  // Two-flop synchroniser; reset parks each flop at its source's inactive level.
  always_ff @(posedge ref_clk) begin
    if (pad_reset) begin
      sync1_q <= SRC_ACTIVE_LOW;
      sync2_q <= SRC_ACTIVE_LOW;
    end else begin
      sync1_q <= src_i;
      sync2_q <= sync1_q;
    end
  end

  // Polarity-normalise (1 = requesting) and drop masked sources.
  always_comb begin
    src_act = (sync2_q ^ SRC_ACTIVE_LOW) & ~src_mask_i;
  end

`ifdef PULPEMU_RST_DEBOUNCE_EN
  localparam logic [7:0] DEB_MAX = 8'(DEBOUNCE_CYCLES);

  logic [7:0] deb_cnt_q [NUM_SRC];
  logic [7:0] deb_cnt_d [NUM_SRC];

  // Saturating run-length counter per source; any inactive sample clears it and drops the request at once.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      deb_cnt_d[i] = '0;
      qual_src[i]  = 1'b0;
      if (src_act[i]) begin
        qual_src[i]  = (deb_cnt_q[i] == DEB_MAX);
        deb_cnt_d[i] = (deb_cnt_q[i] == DEB_MAX) ? deb_cnt_q[i] : deb_cnt_q[i] + 8'd1;
      end
    end
  end

  // Debounce counter registers.
  always_ff @(posedge ref_clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (pad_reset) begin
        deb_cnt_q[i] <= '0;
      end else begin
        deb_cnt_q[i] <= deb_cnt_d[i];
      end
    end
  end
`else
  // Without debounce a synchronised, masked active sample qualifies immediately.
  always_comb begin
    qual_src = src_act;
  end

  // DEBOUNCE_CYCLES has no effect in this build.
  if (DEBOUNCE_CYCLES == 0) begin : g_debounce_unused
  end
`endif

  // Software request bypasses synchroniser and debounce; it sits above the sources in the cause vector.
  always_comb begin
    qual_vec = {sw_rst_req_i, qual_src};
    any_req  = |qual_vec;
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------------
  state_e             state_q, state_d;
  logic [15:0]        stretch_q, stretch_d;
  logic [7:0]         stagger_q, stagger_d;
  logic [NUM_OUT-1:0] rst_n_q, rst_n_d;
  logic               done_q, done_d;
  logic [NUM_OUT-1:0] rel_next;
  logic [NUM_SRC:0]   cause_q, cause_d;

  // State, counters and registered outputs.
  always_ff @(posedge ref_clk) begin
    if (pad_reset) begin
      state_q   <= ST_ASSERT;
      stretch_q <= '0;
      stagger_q <= '0;
      rst_n_q   <= '0;
      done_q    <= 1'b0;
      cause_q   <= '0;
    end else begin
      state_q   <= state_d;
      stretch_q <= stretch_d;
      stagger_q <= stagger_d;
      rst_n_q   <= rst_n_d;
      done_q    <= done_d;
      cause_q   <= cause_d;
    end
  end

  // Next-state: any request restarts ASSERT; idle stretch then thermometer release, one bit per stagger period.
  always_comb begin
    state_d   = state_q;
    stretch_d = stretch_q;
    stagger_d = stagger_q;
    rst_n_d   = rst_n_q;
    done_d    = done_q;
    // Shifting in ones keeps the release pattern monotonic from bit 0 upward.
    rel_next  = (rst_n_q << 1) | FIRST_REL;

    if (any_req) begin
      state_d   = ST_ASSERT;
      stretch_d = '0;
      stagger_d = '0;
      rst_n_d   = '0;
      done_d    = 1'b0;
    end else begin
      case (state_q)
        ST_ASSERT: begin
          rst_n_d = '0;
          done_d  = 1'b0;
          if (stretch_q == STRETCH_LAST) begin
            stretch_d = '0;
            stagger_d = '0;
            rst_n_d   = FIRST_REL;
            if (FIRST_REL == ALL_REL) begin
              state_d = ST_RUN;
              done_d  = 1'b1;
            end else begin
              state_d = ST_RELEASE;
            end
          end else begin
            stretch_d = stretch_q + 16'd1;
          end
        end
        ST_RELEASE: begin
          if (stagger_q == STAGGER_LAST) begin
            stagger_d = '0;
            rst_n_d   = rel_next;
            if (rel_next == ALL_REL) begin
              state_d = ST_RUN;
              done_d  = 1'b1;
            end
          end else begin
            stagger_d = stagger_q + 8'd1;
          end
        end
        ST_RUN: begin
          rst_n_d = ALL_REL;
          done_d  = 1'b1;
        end
        default: begin
          state_d = ST_ASSERT;
          rst_n_d = '0;
          done_d  = 1'b0;
        end
      endcase
    end
  end

  // Sticky cause: clear first, then OR in this cycle's requests so a same-cycle set survives the clear.
  always_comb begin
    cause_d = (cause_clr_i ? '0 : cause_q) | qual_vec;
  end

  assign rst_n_o     = rst_n_q;
  assign rst_done_o  = done_q;
  assign rst_cause_o = cause_q;

endmodule

// File: tb/tb_pulpemu_rst_seq.sv
`timescale 1ns/1ps
module tb_pulpemu_rst_seq;

  localparam int NS   = 2;
  localparam int NO   = 3;
  localparam int DEB  = 4;
  localparam int STR  = 10;
  localparam int STG  = 3;
  localparam int MAXC = 512;
`ifdef PULPEMU_RST_DEBOUNCE_EN
  localparam int QW = DEB + 1;  // consecutive synchronised active samples needed
  localparam int DQ = DEB;      // extra edges from src_i to rst_n_o fall
`else
  localparam int QW = 1;
  localparam int DQ = 0;
`endif

  logic          ref_clk = 1'b0;
  logic          pad_reset;
  logic [NS-1:0] src_i;
  logic [NS-1:0] src_mask_i;
  logic          sw_rst_req_i;
  logic          cause_clr_i;
  logic [NO-1:0] rst_n_o;
  logic          rst_done_o;
  logic [NS:0]   rst_cause_o;

  logic [NS-1:0] sal = 2'b11;

  always #5 ref_clk = ~ref_clk;

  pulpemu_rst_seq #(
    .NUM_SRC(NS), .NUM_OUT(NO), .SRC_ACTIVE_LOW(2'b11),
    .DEBOUNCE_CYCLES(DEB), .STRETCH_CYCLES(STR), .STAGGER_CYCLES(STG)
  ) dut (
    .ref_clk(ref_clk), .pad_reset(pad_reset), .src_i(src_i), .src_mask_i(src_mask_i),
    .sw_rst_req_i(sw_rst_req_i), .cause_clr_i(cause_clr_i),
    .rst_n_o(rst_n_o), .rst_done_o(rst_done_o), .rst_cause_o(rst_cause_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", name, c, act, exp);
  endtask

  // ---------------------------------------------------------------------------
  // Model. Cycle c is the interval after posedge c; inputs of cycle c are
  // sampled at posedge c+1. Outputs are derived from the number of idle
  // cycles since the last reset/request cycle.
  // ---------------------------------------------------------------------------
  logic [NS-1:0] src_h  [MAXC];
  logic [NS-1:0] mask_h [MAXC];
  logic          pad_h  [MAXC];
  int            cyc = 0;
  int            last_hold = -1;
  bit            model_ok = 1'b0;
  bit            running  = 1'b1;
  logic [NO-1:0] exp_rst_n = '0;
  logic          exp_done  = 1'b0;
  logic [NS:0]   exp_cause = '0;

  // Synchronised, normalised, masked request of source i as seen during cycle cc.
  function automatic logic src_act(input int cc, input int i);
    logic v;
    if (cc < 2) return 1'b0;
    if (pad_h[cc-1] || pad_h[cc-2]) return 1'b0;
    v = src_h[cc-2][i];
    if (sal[i]) v = ~v;
    return v & ~mask_h[cc][i];
  endfunction

  initial forever begin
    int c, k, rel;
    logic [NS:0] q;
    @(posedge ref_clk);
    c = cyc;
    src_h[c]  = src_i;
    mask_h[c] = src_mask_i;
    pad_h[c]  = pad_reset;
    q = '0;
    q[NS] = sw_rst_req_i;
    for (int i = 0; i < NS; i++) begin
      q[i] = 1'b1;
      for (int d = 0; d < QW; d++)
        if (!src_act(c - d, i)) q[i] = 1'b0;
    end
    cyc = c + 1;
    if (pad_reset) begin
      last_hold = c;
      exp_cause = '0;
      model_ok  = 1'b1;
    end else begin
      if (q != '0) last_hold = c;
      exp_cause = (cause_clr_i ? '0 : exp_cause) | q;
    end
    if (last_hold >= 0) begin
      k = (cyc - 1) - last_hold;
      if (k < STR) rel = 0;
      else rel = 1 + (k - STR) / STG;
      if (rel > NO) rel = NO;
      exp_rst_n = NO'((1 << rel) - 1);
      exp_done  = (rel == NO);
    end
  end

  // Compare process: every cycle once the model has seen reset.
  initial forever begin
    @(negedge ref_clk);
    if (model_ok && running) begin
      chk("rst_n_o", cyc, 32'(rst_n_o), 32'(exp_rst_n));
      chk("rst_done_o", cyc, 32'(rst_done_o), 32'(exp_done));
      chk("rst_cause_o", cyc, 32'(rst_cause_o), 32'(exp_cause));
    end
  end

  // Returns at the negedge inside cycle e.
  task automatic at(input int e);
    while (cyc < e) @(negedge ref_clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    pad_reset = 1'b1; src_i = 2'b11; src_mask_i = 2'b00; sw_rst_req_i = 1'b0; cause_clr_i = 1'b0;

    // Power-on sequencing.
    at(3);   chk("por_rst_n", cyc, 32'(rst_n_o), 32'h0);
             chk("por_done", cyc, 32'(rst_done_o), 32'h0);
             chk("por_cause", cyc, 32'(rst_cause_o), 32'h0);
    at(5);   pad_reset = 1'b0;
    at(14);  chk("por_hold", cyc, 32'(rst_n_o), 32'h0);
    at(15);  chk("por_rel0", cyc, 32'(rst_n_o), 32'h1);
    at(18);  chk("por_rel1", cyc, 32'(rst_n_o), 32'h3);
             chk("por_notdone", cyc, 32'(rst_done_o), 32'h0);
    at(21);  chk("por_rel2", cyc, 32'(rst_n_o), 32'h7);
             chk("por_done1", cyc, 32'(rst_done_o), 32'h1);
             chk("por_cause0", cyc, 32'(rst_cause_o), 32'h0);

    // Three-cycle glitch on src_i[0].
    at(30);  src_i = 2'b10;
    at(33);  src_i = 2'b11;
`ifndef PULPEMU_RST_DEBOUNCE_EN
             chk("glitch_fall", cyc, 32'(rst_n_o), 32'h0);
             chk("glitch_cause", cyc, 32'(rst_cause_o), 32'h1);
`endif
    at(40);
`ifdef PULPEMU_RST_DEBOUNCE_EN
             chk("glitch_ignored", cyc, 32'(rst_n_o), 32'h7);
             chk("glitch_cause0", cyc, 32'(rst_cause_o), 32'h0);
`else
             chk("glitch_held", cyc, 32'(rst_n_o), 32'h0);
`endif
    at(58);  cause_clr_i = 1'b1;
    at(59);  cause_clr_i = 1'b0;
             chk("clr_cause", cyc, 32'(rst_cause_o), 32'h0);

    // src_i[1] low for 20 cycles.
    at(60);  src_i = 2'b01;
    at(62 + DQ); chk("src1_pre", cyc, 32'(rst_n_o), 32'h7);
    at(63 + DQ); chk("src1_fall", cyc, 32'(rst_n_o), 32'h0);
                 chk("src1_cause", cyc, 32'(rst_cause_o), 32'h2);
    at(80);  src_i = 2'b11;
    at(91);  chk("src1_stretch", cyc, 32'(rst_n_o), 32'h0);
    at(92);  chk("src1_rel0", cyc, 32'(rst_n_o), 32'h1);
    at(98);  chk("src1_rel2", cyc, 32'(rst_n_o), 32'h7);
             chk("src1_cause2", cyc, 32'(rst_cause_o), 32'h2);

    // Re-request while only bit 0 is released.
    at(105); sw_rst_req_i = 1'b1;
    at(106); sw_rst_req_i = 1'b0;
             chk("sw_fall", cyc, 32'(rst_n_o), 32'h0);
    at(116); chk("rr_rel0", cyc, 32'(rst_n_o), 32'h1);
    at(117); sw_rst_req_i = 1'b1;
    at(118); sw_rst_req_i = 1'b0;
             chk("rr_fall", cyc, 32'(rst_n_o), 32'h0);
    at(127); chk("rr_stretch", cyc, 32'(rst_n_o), 32'h0);
    at(128); chk("rr_rel0b", cyc, 32'(rst_n_o), 32'h1);
    at(134); chk("rr_rel2", cyc, 32'(rst_n_o), 32'h7);
             chk("rr_cause", cyc, 32'(rst_cause_o), 32'h6);

    // Software request with a same-cycle cause clear while cause = 001.
    at(140); cause_clr_i = 1'b1;
    at(141); cause_clr_i = 1'b0;
    at(145); src_i = 2'b10;
    at(155); src_i = 2'b11;
    at(158); chk("s0_cause", cyc, 32'(rst_cause_o), 32'h1);
    at(175); chk("s0_run", cyc, 32'(rst_n_o), 32'h7);
    at(180); sw_rst_req_i = 1'b1; cause_clr_i = 1'b1;
    at(181); sw_rst_req_i = 1'b0; cause_clr_i = 1'b0;
             chk("setwins_cause", cyc, 32'(rst_cause_o), 32'h4);
             chk("setwins_fall", cyc, 32'(rst_n_o), 32'h0);
    at(197); chk("setwins_run", cyc, 32'(rst_n_o), 32'h7);
             chk("setwins_done", cyc, 32'(rst_done_o), 32'h1);

    // Masked source held active for 50 cycles.
    at(200); src_mask_i = 2'b01; src_i = 2'b10;
    at(230); chk("mask_rst_n", cyc, 32'(rst_n_o), 32'h7);
             chk("mask_cause", cyc, 32'(rst_cause_o), 32'h4);
    at(250); src_i = 2'b11;
    at(253); chk("mask_after", cyc, 32'(rst_n_o), 32'h7);
    at(260); src_mask_i = 2'b00;

    // pad_reset in the middle of RELEASE.
    at(270); sw_rst_req_i = 1'b1;
    at(271); sw_rst_req_i = 1'b0;
    at(281); chk("pad_rel0", cyc, 32'(rst_n_o), 32'h1);
    at(284); chk("pad_rel1", cyc, 32'(rst_n_o), 32'h3);
    at(285); pad_reset = 1'b1;
    at(286); pad_reset = 1'b0;
             chk("pad_fall", cyc, 32'(rst_n_o), 32'h0);
             chk("pad_cause", cyc, 32'(rst_cause_o), 32'h0);
    at(295); chk("pad_stretch", cyc, 32'(rst_n_o), 32'h0);
    at(296); chk("pad_rel0b", cyc, 32'(rst_n_o), 32'h1);
    at(302); chk("pad_run", cyc, 32'(rst_n_o), 32'h7);
             chk("pad_done", cyc, 32'(rst_done_o), 32'h1);

    at(310);
    running = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
